// File: rtl/post_proc_sequencer.sv
// Output mux sequencer choosing between the activation and 2x2/stride-2 pooling paths.
// Define POST_PROC_PERF_EN to add the stall_cnt/out_cnt performance counters.
module post_proc_sequencer #(
    parameter int unsigned DIM_W      = 8,
    parameter logic        ACTIVATION = 1'b0,
    parameter logic        POOLING    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cfg_pool_en,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel,
    output logic             pool_wr,
    output logic             pool_emit,
    output logic             busy,
    output logic             done
`ifdef POST_PROC_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [2*DIM_W-1:0]   out_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYPASS = 2'd1,
        POOL   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] row_q, col_q, width_q, height_q;
    logic [DIM_W-1:0] width_even, height_even;
    logic             cfg_load, accept, in_region, emit, col_end, last;

    // Pooling windows only cover the even-cropped part of the frame.
    assign width_even  = {width_q[DIM_W-1:1], 1'b0};
    assign height_even = {height_q[DIM_W-1:1], 1'b0};
    assign in_region   = (col_q < width_even) && (row_q < height_even);
    assign emit        = in_region && row_q[0] && col_q[0];
    assign col_end     = (col_q == width_q - DIM_W'(1));
    assign last        = col_end && (row_q == height_q - DIM_W'(1));

    // Next-state and handshake gating.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        pool_wr   = 1'b0;
        pool_emit = 1'b0;
        cfg_load  = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_load = 1'b1;
                    if (cfg_width == '0 || cfg_height == '0) state_d = FINISH;
                    else if (cfg_pool_en)                    state_d = POOL;
                    else                                     state_d = BYPASS;
                end
            end
            BYPASS: begin
                out_valid = in_valid;
                in_ready  = out_ready;
                accept    = in_valid && out_ready;
                if (accept && last) state_d = FINISH;
            end
            POOL: begin
                if (emit) begin
                    out_valid = in_valid;
                    in_ready  = out_ready;
                    pool_emit = in_valid;
                end else begin
                    in_ready  = 1'b1;
                end
                accept  = in_valid && in_ready;
                pool_wr = accept && in_region;
                if (accept && last) state_d = FINISH;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            sel      <= ACTIVATION;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            sel     <= (state_d == POOL) ? POOLING : ACTIVATION;
            busy    <= (state_d != IDLE);
            done    <= (state_d == FINISH);
            if (cfg_load) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
                row_q    <= '0;
                col_q    <= '0;
            end else if (accept) begin
                if (col_end) begin
                    col_q <= '0;
                    row_q <= row_q + DIM_W'(1);
                end else begin
                    col_q <= col_q + DIM_W'(1);
                end
            end
        end
    end

`ifdef POST_PROC_PERF_EN
    // Counters clear on frame start and hold after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            out_cnt   <= '0;
        end else if (cfg_load) begin
            stall_cnt <= '0;
            out_cnt   <= '0;
        end else begin
            if (busy && out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
            if (out_valid && out_ready)          out_cnt   <= out_cnt + (2*DIM_W)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_post_proc_sequencer.sv
// Scoreboard bench for post_proc_sequencer: expected output positions are queued
// when a frame is configured and popped as the DUT hands each output to the writer.
module tb_post_proc_sequencer;

    localparam int unsigned DIM_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, cfg_pool_en, in_valid, out_ready;
    logic [DIM_W-1:0] cfg_width, cfg_height;
    logic             in_ready, out_valid, sel, pool_wr, pool_emit, busy, done;
`ifdef POST_PROC_PERF_EN
    logic [31:0]        stall_cnt;
    logic [2*DIM_W-1:0] out_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    post_proc_sequencer #(.DIM_W(DIM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_pool_en(cfg_pool_en),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .sel(sel), .pool_wr(pool_wr), .pool_emit(pool_emit),
        .busy(busy), .done(done)
`ifdef POST_PROC_PERF_EN
        , .stall_cnt(stall_cnt), .out_cnt(out_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_region(int r, int c, int w, int h);
        return (c < (w / 2) * 2) && (r < (h / 2) * 2);
    endfunction

    function automatic bit m_emit(int r, int c, int w, int h);
        return m_region(r, c, w, h) && (r % 2 == 1) && (c % 2 == 1);
    endfunction

    // Runs one frame with continuous input; the 2nd emit may be stalled and a
    // stray start may be injected mid-frame.
    task automatic run_frame(input bit pool, input int w, input int h,
                             input int stall_len, input bit mid_start);
        int  r = 0, c = 0, accepted = 0, emit_seen = 0, stall = 0, cyc = 0, n_out = 0, n_exp = 0;
        bit  emit_now, exp_rdy, mid_sent = 0;
        for (int rr = 0; rr < h; rr++)
            for (int cc = 0; cc < w; cc++)
                if (!pool || m_emit(rr, cc, w, h)) begin
                    exp_q.push_back(rr * 256 + cc);
                    n_exp++;
                end
        @(negedge clk);
        start = 1'b1; cfg_pool_en = pool;
        cfg_width = DIM_W'(w); cfg_height = DIM_W'(h);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (accepted < w * h && cyc < 2000) begin
            in_valid  = 1'b1;
            emit_now  = pool ? m_emit(r, c, w, h) : 1'b1;
            out_ready = !(pool && emit_now && emit_seen == 1 && stall < stall_len);
            start     = 1'b0;
            if (mid_start && accepted == 2 && !mid_sent) begin
                start = 1'b1; cfg_width = '0; cfg_pool_en = !pool;
                mid_sent = 1'b1;
            end
            #1;
            exp_rdy = (pool && !emit_now) ? 1'b1 : out_ready;
            check("sel", sel, pool);
            check("busy", busy, 1);
            check("out_valid", out_valid, emit_now);
            check("in_ready", in_ready, exp_rdy);
            check("pool_emit", pool_emit, pool && emit_now);
            check("pool_wr", pool_wr, pool && exp_rdy && m_region(r, c, w, h));
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check("unexpected_out", r * 256 + c, 32'hffff);
                else                   check("out_pos", r * 256 + c, exp_q.pop_front());
            end
            if (!exp_rdy) stall++;
            if (exp_rdy) begin
                if (emit_now) emit_seen++;
                accepted++;
                if (c == w - 1) begin c = 0; r++; end
                else c++;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 2000) check("timeout", cyc, 0);
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        #1;
        check("done_pulse", done, 1);
        check("busy_finish", busy, 1);
        check("sel_finish", sel, 0);
        check("out_count", n_out, n_exp);
        check("queue_empty", exp_q.size(), 0);
`ifdef POST_PROC_PERF_EN
        check("out_cnt", out_cnt, n_exp);
        check("stall_cnt", stall_cnt, stall_len);
`endif
        @(negedge clk);
        #1;
        check("done_fall", done, 0);
        check("busy_fall", busy, 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_pool_en = 1'b0; cfg_width = '0; cfg_height = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel", sel, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_frame(1'b0, 3, 2, 0, 1'b0);
        run_frame(1'b1, 4, 4, 0, 1'b1);
        run_frame(1'b1, 5, 3, 0, 1'b0);
        run_frame(1'b1, 4, 4, 3, 1'b0);
        run_frame(1'b1, 1, 4, 0, 1'b0);

        // Zero width finishes immediately without accepting anything.
        @(negedge clk);
        start = 1'b1; cfg_pool_en = 1'b1; cfg_width = '0; cfg_height = 8'd3; in_valid = 1'b1;
        #1;
        check("zero_idle_ready", in_ready, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("zero_done", done, 1);
        check("zero_in_ready", in_ready, 0);
        check("zero_out_valid", out_valid, 0);
        @(negedge clk);
        #1;
        check("zero_done_fall", done, 0);
        check("zero_busy_fall", busy, 0);
        in_valid = 1'b0;

        // Reset during row 1 aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; cfg_pool_en = 1'b1; cfg_width = 8'd4; cfg_height = 8'd4;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sel", sel, 0);
        check("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("abort_no_done", done, 0);
        run_frame(1'b1, 4, 4, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/post_proc_sequencer.md
Name: post_proc_sequencer

Overview:
- Controller for the post-processing output select mux that chooses between the activation path and the pooling path.
- Per layer, it latches a frame configuration and counts the row-major activation stream position (row/col).
- Drives the mux select, gates the valid/ready handshake to the downstream writer, and strobes the 2x2/stride-2 pooling unit.
- Sits between the activation stage and the output buffer writer.

Parameters:
- DIM_W, 8, width of the frame width/height config and of the row/col counters.
- ACTIVATION, 1'b0, select encoding for the activation path.
- POOLING, 1'b1, select encoding for the pooling path.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse that latches the config and begins a frame
- cfg_pool_en  input  1  1 = 2x2/stride-2 pooling, 0 = activation bypass
- cfg_width  input  DIM_W  frame columns
- cfg_height  input  DIM_W  frame rows
- in_valid  input  1  activation element valid
- in_ready  output  1  sequencer accepts the current element
- out_valid  output  1  mux output valid to the writer
- out_ready  input  1  writer accepts the output
- sel  output  1  mux select (ACTIVATION/POOLING)
- pool_wr  output  1  pooling unit stores the current element in its line/window buffer
- pool_emit  output  1  pooling unit presents the window result this cycle
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset values: state=IDLE; row, col, width, height and mode registers = 0; sel=ACTIVATION; done=0. All other outputs are combinationally 0 in IDLE.
- FSM states: IDLE, BYPASS, POOL, FINISH.
- IDLE:
  - in_ready=0.
  - start=1: latch cfg_*, clear row/col.
  - Either dimension = 0 -> FINISH.
  - Otherwise cfg_pool_en=1 -> POOL; cfg_pool_en=0 -> BYPASS.
- Transfer: an element is accepted when in_valid && in_ready (the "accept" condition below).
- Counters:
  - On accept, col increments.
  - At col==width-1, col wraps to 0 and row increments.
  - The last element is row==height-1 && col==width-1; its accept moves the FSM to FINISH.
- BYPASS:
  - sel=ACTIVATION, pool_wr=0, pool_emit=0.
  - out_valid=in_valid, in_ready=out_ready; every element is forwarded.
- POOL (sel=POOLING):
  - An element is an emit element when row[0]==1, col[0]==1, col<=width_even-1 and row<=height_even-1, where width_even/height_even are the dimensions rounded down to even.
  - Emit element: out_valid=in_valid, in_ready=out_ready, pool_emit=in_valid.
  - Non-emit element: out_valid=0, in_ready=1 (the element is absorbed).
  - pool_wr=accept for every element inside the even-cropped region; elements outside it are consumed and dropped.
  - Odd trailing column/row: floor semantics, no output. A 1-wide or 1-high frame produces zero outputs and still completes.
- FINISH: done=1 for exactly one cycle, sel returns to ACTIVATION, next state IDLE.
- busy=1 in BYPASS, POOL and FINISH.
- start while not in IDLE is ignored; the config stays frozen for the whole frame.
- Holding in_valid while in_ready=0 changes no counter.
- The output handshake is combinational pass-through: zero added latency, no buffering.
- rst asserted mid-frame aborts immediately to the reset values, with no done pulse.
- Counters are DIM_W wide; width/height up to 2^DIM_W-1 are supported without overflow because the wrap occurs at width-1.

Optional Feature:
- Macro: POST_PROC_PERF_EN.
- When defined:
  - Adds output stall_cnt [31:0], counting cycles with out_valid && !out_ready while busy.
  - Adds output out_cnt [2*DIM_W-1:0], counting accepted outputs.
  - Both clear on start accept and on rst, and hold after done.
- When undefined: neither port nor its logic exists; behaviour is otherwise identical.

Test Plan:
- Bypass 3x2 frame, out_ready=1, in_valid every cycle -> 6 outputs with sel=0; done pulses the cycle after the 6th accept; busy falls with done.
- Pool 4x4, continuous input -> 4 outputs, on elements (row,col)=(1,1),(1,3),(3,1),(3,3); sel=1; pool_wr=1 on all 16.
- Pool 5x3 (odd) -> 2 outputs at (1,1),(1,3); column 4 and row 2 consumed with pool_wr=0; done after the 15th accept.
- Pool 4x4 with out_ready low for 3 cycles on the 2nd emit -> in_ready=0 and counters hold; the output is delivered after release; total stays 4 (PERF: stall_cnt=3).
- start with cfg_width=0 -> FINISH next cycle, done pulse, no in_ready; start asserted mid-frame is ignored.
- rst pulse during row 1 of a 4x4 pool frame -> busy=0 immediately, no done; a new start runs a full frame correctly.
